// File: rtl/alu_pkg.sv
// Shared definitions for the add_subtract issuer: opcodes, FSM states,
// flag bit positions and the supported-opcode decoder.
package alu_pkg;

    localparam int OP_WIDTH = 4;

    localparam logic [OP_WIDTH-1:0] OP_NOP = 4'b0000;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 4'b0010;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic is_supported(
        input logic [OP_WIDTH-1:0] op
    );
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): ok = 1'b1;
            (op == OP_SUB): ok = 1'b1;
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_latency_counter.sv
// Load/decrement latency counter; done is high while the count is zero.
// Ports: clock, reset_n (sync, active-low), load, load_value, dec, count, done.
module alu_latency_counter #(
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          done
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one command at a time to add_subtract and returns its result.
// Ports: clock, reset_n, cmd_* (valid/ready in), alu_* (to/from ALU),
// rsp_* (valid/ready out), busy. ALU_ISSUER_FLAGS_EN adds rsp_flags.
module alu_op_issuer #(
    parameter int WIDTH       = 4,
    parameter int OP_WIDTH    = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_WIDTH-1:0] cmd_op,
    input  logic [WIDTH-1:0]    cmd_a,
    input  logic [WIDTH-1:0]    cmd_b,
    output logic [OP_WIDTH-1:0] alu_op,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    input  logic [WIDTH-1:0]    alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_result,
    output logic                rsp_err,
`ifdef ALU_ISSUER_FLAGS_EN
    output logic [3:0]          rsp_flags,
`endif
    output logic                busy
);

    import alu_pkg::*;

    localparam int CW = 4;
    localparam logic [CW-1:0] LAT = CW'(ALU_LATENCY);

    state_t state;

    logic          accept;
    logic          legal;
    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt;
    logic          cnt_done;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign legal     = is_supported(cmd_op);
    assign cnt_load  = accept && legal;
    assign cnt_dec   = (state == DRIVE);

    // Operands are registered at accept, so the ALU sees them one cycle
    // later; the counter then runs LAT more cycles before capture.
    alu_latency_counter #(.CW(CW)) u_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (LAT),
        .dec        (cnt_dec),
        .count      (cnt),
        .done       (cnt_done)
    );

`ifdef ALU_ISSUER_FLAGS_EN
    function automatic logic [3:0] calc_flags(
        input logic [OP_WIDTH-1:0] op,
        input logic [WIDTH-1:0]    a,
        input logic [WIDTH-1:0]    b
    );
        logic [WIDTH:0] s;
        logic           v;
        logic [3:0]     f;
        if (op == OP_SUB) begin
            // C is the carry of a + ~b + 1, i.e. no-borrow
            s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            v = (a[WIDTH-1] != b[WIDTH-1]) &&
                (s[WIDTH-1] != a[WIDTH-1]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            v = (a[WIDTH-1] == b[WIDTH-1]) &&
                (s[WIDTH-1] != a[WIDTH-1]);
        end
        f         = '0;
        f[FLAG_N] = s[WIDTH-1];
        f[FLAG_Z] = (s[WIDTH-1:0] == '0);
        f[FLAG_C] = s[WIDTH];
        f[FLAG_V] = v;
        return f;
    endfunction
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            alu_op     <= OP_NOP;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
`ifdef ALU_ISSUER_FLAGS_EN
            rsp_flags  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            alu_op <= cmd_op;
                            alu_a  <= cmd_a;
                            alu_b  <= cmd_b;
                            state  <= DRIVE;
                        end else begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
`ifdef ALU_ISSUER_FLAGS_EN
                            rsp_flags  <= '0;
`endif
                            state      <= RESP;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_done) begin
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
`ifdef ALU_ISSUER_FLAGS_EN
                        rsp_flags  <= calc_flags(alu_op, alu_a, alu_b);
`endif
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        alu_op    <= OP_NOP;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
